updown_counter_p: RTL and testbench
===================================

# updown_counter_p

Parametrised up/down event counter for the lab datapath, next generation of the display counters. Counts enabled, prescaled clock ticks and edge-detected single-step pulses in either direction. A free_run mode wraps between 0 and a programmable limit; otherwise the count saturates at that limit. Provides synchronous load, a terminal-count pulse and a saturation flag, and drives the seven-segment/LED display path directly from `count`.

## Interface
- `WIDTH`, 24, counter and limit width in bits (≥ 2)
- `PRESCALE`, 1, enabled clock cycles per tick (≥ 1); prescaler width is clog2(PRESCALE), min 1
- `clk`  input  1  sole clock, all state updates on rising edge
- `reset`  input  1  asynchronous, active-low; 0 clears all state immediately
- `enable`  input  1  1 = prescaler runs and ticks advance the count
- `step`  input  1  single-step request; rising edge (0→1 between consecutive samples) = one event, independent of `enable`; already synchronous to `clk`
- `up_down`  input  1  1 = increment, 0 = decrement
- `free_run`  input  1  1 = wrap at bounds, 0 = saturate at bounds
- `load`  input  1  synchronous load strobe
- `load_val`  input  WIDTH  value for `load`
- `limit`  input  WIDTH  upper bound; lower bound fixed at 0
- `count`  output  WIDTH  registered count value
- `tc`  output  1  registered one-cycle pulse on wrap
- `sat`  output  1  registered level, 1 while a saturating step is blocked

## Operation
- State: `count`, prescaler `pre` (0..PRESCALE-1), `step_q` (last sampled `step`), `tc`, `sat`.
- Tick: `enable`=1 and `pre`==PRESCALE-1. `pre` increments when `enable`=1, wraps to 0 on tick, is forced to 0 when `enable`=0 or `load`=1.
- Event: tick OR (`step`=1 AND `step_q`=0). A coincident tick and step edge are one event (advance by 1, not 2).
- Priority per edge: `load` > event > hold.
- Load: `count` ← min(`load_val`, `limit`); `tc` ← 0; `sat` ← 0; a simultaneous event is discarded.
- Up event, `count` < `limit`: `count`+1, `sat` ← 0.
- Up event, `count` ≥ `limit`: free_run=1 → `count` ← 0, `tc` ← 1; free_run=0 → `count` ← `limit`, `sat` ← 1.
- Down event, `count` > 0: `count`−1, `sat` ← 0; if `count` > `limit` (limit lowered), `count` ← `limit` instead.
- Down event, `count` = 0: free_run=1 → `count` ← `limit`, `tc` ← 1; free_run=0 → hold 0, `sat` ← 1.
- No event, no load: `count` holds, `tc` ← 0, `sat` holds.
- `limit` = 0: every event leaves `count` at 0; `tc` pulses in free_run, `sat` sets otherwise.
- `limit` = 2^WIDTH−1: full-range counter; up-wrap to 0 and down-wrap to all-ones.
- Arithmetic is WIDTH-bit unsigned; bound comparisons happen before the ±1, so no wrap through binary overflow.

## Timing
- Reset (`reset`=0, asynchronous): `count`=0, `tc`=0, `sat`=0, `pre`=0, `step_q`=0. Release is synchronous to the next `clk` edge. A reset asserted mid-count discards any pending event.
- Latency: an event or load sampled at edge N is visible on `count`/`tc`/`sat` after edge N (1 cycle).
- Tick rate with `enable` held high: one event every PRESCALE cycles; the first tick occurs PRESCALE edges after `enable` rises.
- `tc` is high for exactly one cycle per wrap. Consecutive wraps (e.g. `limit`=0, PRESCALE=1) give `tc` high continuously.
- `step` held high produces one event only. It must return low for ≥1 sampled cycle before the next edge registers.

## Test plan
- Reset/load: `reset`=0 mid-count with `count`=0x00001F → `count`, `tc`, `sat` read 0 before the next `clk` edge. Then `load`=1, `load_val`=0x000010, `limit`=0x00000F → `count`=0x00000F.
- Up wrap: WIDTH=24, PRESCALE=1, `limit`=5, free_run=1, up, `enable`=1 from 0 → `count` 1,2,3,4,5,0,1. `tc` high only in the cycle `count`=0.
- Down saturate: free_run=0, up_down=0, from `count`=2 → 1,0,0,0. `sat` goes 1 on the first blocked event. Flipping to up → `count`=1, `sat`=0.
- Prescale: PRESCALE=4, `enable` high 12 cycles from 0, up, `limit`=0xFFFFFF → `count`=3. Dropping `enable` for 2 cycles, then re-enabling → the next increment comes 4 cycles later.
- Step: `enable`=0, `step` high 5 cycles, low 1, high 1 → `count`=+2. A step edge coinciding with a tick (`enable`=1, PRESCALE=1) → +1 only. A `load` coinciding with a step edge → `load_val` only.
- Limit change: `count`=10, `limit` lowered to 4 → down event gives `count`=4. Up event with free_run=1 gives 0 and a `tc` pulse.

Source files
------------

// File: rtl/updown_counter_p.sv
// updown_counter_p: prescaled up/down event counter with wrap or saturate
// at a programmable limit, synchronous load, tc pulse and sat flag.
//
// Ports:
//   clk      : sole clock, rising edge
//   reset    : asynchronous active-low clear of all state
//   enable   : run prescaler; each prescaler tick is one count event
//   step     : single-step request, rising edge is one event
//   up_down  : 1 = increment, 0 = decrement
//   free_run : 1 = wrap between 0 and limit, 0 = saturate
//   load     : synchronous load of min(load_val, limit)
//   load_val : value for load
//   limit    : upper bound (lower bound is 0)
//   count    : registered count
//   tc       : registered one-cycle pulse on each wrap
//   sat      : registered level while a saturating event is blocked
module updown_counter_p #(
   parameter int WIDTH    = 24,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             step,
   input  logic             up_down,
   input  logic             free_run,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             sat
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic             step_q;
   logic             tc_q, tc_d;
   logic             sat_q, sat_d;

   logic tick;
   logic step_edge;
   logic evt;

   assign tick      = enable && (pre_q == PRE_LAST);
   assign step_edge = step && !step_q;
   // A tick and a step edge in the same cycle advance the count once.
   assign evt       = tick || step_edge;

   always_comb begin
      pre_d = pre_q;
      if (!enable || load || tick) begin
         pre_d = '0;
      end else begin
         pre_d = pre_q + PW'(1);
      end
   end

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      sat_d   = sat_q;
      if (load) begin
         count_d = (load_val > limit) ? limit : load_val;
         sat_d   = 1'b0;
      end else if (evt) begin
         if (up_down) begin
            // Compare before +1 so the count never wraps through overflow.
            if (count_q < limit) begin
               count_d = count_q + WIDTH'(1);
               sat_d   = 1'b0;
            end else if (free_run) begin
               count_d = '0;
               tc_d    = 1'b1;
            end else begin
               count_d = limit;
               sat_d   = 1'b1;
            end
         end else begin
            if (count_q != '0) begin
               // A limit lowered below the count pulls it straight down.
               count_d = (count_q > limit) ? limit
                                           : count_q - WIDTH'(1);
               sat_d   = 1'b0;
            end else if (free_run) begin
               count_d = limit;
               tc_d    = 1'b1;
            end else begin
               sat_d   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         pre_q   <= '0;
         step_q  <= 1'b0;
         tc_q    <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         pre_q   <= pre_d;
         step_q  <= step;
         tc_q    <= tc_d;
         sat_q   <= sat_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign sat   = sat_q;

endmodule

// File: tb/tb_updown_counter_p.sv
// tb_updown_counter_p: scoreboard bench for updown_counter_p
// (PRESCALE=1 and PRESCALE=4 instances on shared stimulus).
module tb_updown_counter_p;

   typedef struct packed {
      logic [23:0] c;
      logic        tc;
      logic        sat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable, step, up_down, free_run, load;
   logic [23:0] load_val, limit;
   logic [23:0] cnt1, cnt4;
   logic        tc1, sat1, tc4, sat4;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   updown_counter_p #(.WIDTH(24), .PRESCALE(1)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .step(step),
      .up_down(up_down), .free_run(free_run), .load(load),
      .load_val(load_val), .limit(limit),
      .count(cnt1), .tc(tc1), .sat(sat1)
   );

   updown_counter_p #(.WIDTH(24), .PRESCALE(4)) dut4 (
      .clk(clk), .reset(reset), .enable(enable), .step(step),
      .up_down(up_down), .free_run(free_run), .load(load),
      .load_val(load_val), .limit(limit),
      .count(cnt4), .tc(tc4), .sat(sat4)
   );

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if ({cnt1, tc1, sat1} !== 26'd0) begin
         errors++;
         $display("FAIL reset_init: count=%h tc=%b sat=%b, want 0 0 0",
                  cnt1, tc1, sat1);
      end
      reset = 1'b1;
      load = 1'b1; load_val = 24'h1F; limit = 24'hFFFFFF;
      exp_q.push_back('{c: 24'h1F, tc: 1'b0, sat: 1'b0});
      edge1();
      e = exp_q.pop_front();
      checks++;
      if ({cnt1, tc1, sat1} !== {e.c, e.tc, e.sat}) begin
         errors++;
         $display("FAIL reset_pre: count=%h tc=%b sat=%b, want %h %b %b",
                  cnt1, tc1, sat1, e.c, e.tc, e.sat);
      end
      load = 1'b0;
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({cnt1, tc1, sat1} !== 26'd0) begin
         errors++;
         $display("FAIL reset_async: count=%h tc=%b sat=%b, want 0 0 0",
                  cnt1, tc1, sat1);
      end
      reset = 1'b1;
      load = 1'b1; load_val = 24'h10; limit = 24'h0F;
      exp_q.push_back('{c: 24'h0F, tc: 1'b0, sat: 1'b0});
      edge1();
      e = exp_q.pop_front();
      checks++;
      if ({cnt1, tc1, sat1} !== {e.c, e.tc, e.sat}) begin
         errors++;
         $display("FAIL load_clip: count=%h tc=%b sat=%b, want %h %b %b",
                  cnt1, tc1, sat1, e.c, e.tc, e.sat);
      end
      load = 1'b0;
   endtask

   task automatic test_up_wrap();
      logic [23:0] seq [7] = '{1, 2, 3, 4, 5, 0, 1};
      load = 1'b1; load_val = 24'd0; limit = 24'd5;
      free_run = 1'b1; up_down = 1'b1; enable = 1'b0;
      exp_q.push_back('{c: 24'd0, tc: 1'b0, sat: 1'b0});
      edge1();
      load = 1'b0; enable = 1'b1;
      for (int i = 0; i < 7; i++)
         exp_q.push_back('{c: seq[i], tc: (seq[i] == 0), sat: 1'b0});
      for (int i = 0; i < 8; i++) begin
         if (i > 0) edge1();
         e = exp_q.pop_front();
         checks++;
         if ({cnt1, tc1, sat1} !== {e.c, e.tc, e.sat}) begin
            errors++;
            $display("FAIL up_wrap[%0d]: count=%h tc=%b sat=%b, want %h %b %b",
                     i, cnt1, tc1, sat1, e.c, e.tc, e.sat);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_down_sat();
      logic [23:0] c_s [6] = '{2, 1, 0, 0, 0, 1};
      logic        s_s [6] = '{0, 0, 0, 1, 1, 0};
      load = 1'b1; load_val = 24'd2; limit = 24'd5; free_run = 1'b0;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back('{c: c_s[i], tc: 1'b0, sat: s_s[i]});
         edge1();
         e = exp_q.pop_front();
         checks++;
         if ({cnt1, tc1, sat1} !== {e.c, e.tc, e.sat}) begin
            errors++;
            $display("FAIL down_sat[%0d]: count=%h tc=%b sat=%b, want %h %b %b",
                     i, cnt1, tc1, sat1, e.c, e.tc, e.sat);
         end
         load = 1'b0; enable = 1'b1;
         up_down = (i >= 4);
      end
      enable = 1'b0; up_down = 1'b1;
   endtask

   task automatic test_prescale();
      load = 1'b1; load_val = 24'd0; limit = 24'hFFFFFF;
      up_down = 1'b1; free_run = 1'b0; enable = 1'b0;
      for (int i = 0; i < 19; i++) begin
         if (i == 0)
            exp_q.push_back('{c: 24'd0, tc: 1'b0, sat: 1'b0});
         else if (i <= 12)
            exp_q.push_back('{c: 24'(i / 4), tc: 1'b0, sat: 1'b0});
         else if (i < 18)
            exp_q.push_back('{c: 24'd3, tc: 1'b0, sat: 1'b0});
         else
            exp_q.push_back('{c: 24'd4, tc: 1'b0, sat: 1'b0});
         edge1();
         e = exp_q.pop_front();
         checks++;
         if ({cnt4, tc4, sat4} !== {e.c, e.tc, e.sat}) begin
            errors++;
            $display("FAIL prescale[%0d]: count=%h tc=%b sat=%b, want %h %b %b",
                     i, cnt4, tc4, sat4, e.c, e.tc, e.sat);
         end
         load = 1'b0;
         enable = !(i == 12 || i == 13);
      end
      enable = 1'b0;
   endtask

   task automatic test_step();
      logic        st [12] = '{1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0};
      logic        en [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      logic        ld [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      logic [23:0] ex [12] = '{1, 1, 1, 1, 1, 1, 2, 2, 3, 3, 64, 64};
      load = 1'b1; load_val = 24'd0; limit = 24'hFFFFFF;
      enable = 1'b0; up_down = 1'b1; free_run = 1'b0; step = 1'b0;
      edge1();
      load_val = 24'h40;
      for (int i = 0; i < 12; i++) begin
         step = st[i]; enable = en[i]; load = ld[i];
         exp_q.push_back('{c: ex[i], tc: 1'b0, sat: 1'b0});
         edge1();
         e = exp_q.pop_front();
         checks++;
         if ({cnt1, tc1, sat1} !== {e.c, e.tc, e.sat}) begin
            errors++;
            $display("FAIL step[%0d]: count=%h tc=%b sat=%b, want %h %b %b",
                     i, cnt1, tc1, sat1, e.c, e.tc, e.sat);
         end
      end
      load = 1'b0; step = 1'b0; enable = 1'b0;
   endtask

   task automatic test_limit_change();
      logic        st [4] = '{1, 0, 1, 0};
      logic        ud [4] = '{0, 0, 1, 1};
      logic [23:0] ex [4] = '{4, 4, 0, 0};
      logic        et [4] = '{0, 0, 1, 0};
      load = 1'b1; load_val = 24'd10; limit = 24'hFFFFFF;
      edge1();
      load = 1'b0; limit = 24'd4; free_run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step = st[i]; up_down = ud[i];
         exp_q.push_back('{c: ex[i], tc: et[i], sat: 1'b0});
         edge1();
         e = exp_q.pop_front();
         checks++;
         if ({cnt1, tc1, sat1} !== {e.c, e.tc, e.sat}) begin
            errors++;
            $display("FAIL limit_chg[%0d]: count=%h tc=%b sat=%b, want %h %b %b",
                     i, cnt1, tc1, sat1, e.c, e.tc, e.sat);
         end
      end
      step = 1'b0;
   endtask

   task automatic test_bounds();
      // limit = 0, then the full 24-bit range.
      logic [23:0] lim [10] = '{0, 0, 0, 0, 0, 0,
                                24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
      logic        ld [10] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      logic        en [10] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
      logic        fr [10] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
      logic        st [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
      logic        ud [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      logic [23:0] ex [10] = '{0, 0, 0, 0, 0, 0,
                               24'hFFFFFF, 0, 0, 24'hFFFFFF};
      logic        et [10] = '{0, 1, 1, 1, 0, 0, 0, 1, 0, 1};
      logic        es [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
      load_val = 24'hFFFFFF;
      for (int i = 0; i < 10; i++) begin
         limit = lim[i]; load = ld[i]; enable = en[i];
         free_run = fr[i]; step = st[i]; up_down = ud[i];
         exp_q.push_back('{c: ex[i], tc: et[i], sat: es[i]});
         edge1();
         e = exp_q.pop_front();
         checks++;
         if ({cnt1, tc1, sat1} !== {e.c, e.tc, e.sat}) begin
            errors++;
            $display("FAIL bounds[%0d]: count=%h tc=%b sat=%b, want %h %b %b",
                     i, cnt1, tc1, sat1, e.c, e.tc, e.sat);
         end
      end
      step = 1'b0; load = 1'b0; enable = 1'b0;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; step = 1'b0; up_down = 1'b1;
      free_run = 1'b0; load = 1'b0; load_val = '0; limit = '0;
      repeat (2) edge1();
      test_reset();
      test_up_wrap();
      test_down_sat();
      test_prescale();
      test_step();
      test_limit_change();
      test_bounds();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: run still active at 200000, want finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
